// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the trv_proc instruction fetch queue.
//   FETCH_Q_DEPTH : default number of queue entries
//   PC_W / INST_W : default program-counter / instruction widths
//   fetch_entry_t : one buffered {pc, inst} pair
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_Q_DEPTH = 4;
  localparam int PC_W          = 32;
  localparam int INST_W        = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
// Read/write pointer control for the fetch queue circular buffer. Pointers
// carry one extra wrap bit so full and empty can be told apart without a
// separate occupancy register; occupancy is the pointer difference.
// Ports:
//   CLK, RST_N    : clock, asynchronous active-low reset
//   flush         : return both pointers to 0 (beats push/pop)
//   i_push/i_pop  : accepted write / read this cycle
//   o_wr_idx      : storage index for the next write
//   o_rd_idx      : storage index of the head entry
//   o_full        : all DEPTH entries occupied
//   o_empty       : no entries occupied
//   o_count       : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH)-1:0]   o_wr_idx,
  output logic [$clog2(DEPTH)-1:0]   o_rd_idx,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0] r_wr_ptr;
  logic [IW:0] r_rd_ptr;

  // Pointer update: flush clears both pointers, otherwise advance on handshakes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + {{IW{1'b0}}, 1'b1};
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + {{IW{1'b0}}, 1'b1};
      end
    end
  end

  assign o_wr_idx = r_wr_ptr[IW-1:0];
  assign o_rd_idx = r_rd_ptr[IW-1:0];
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  // Same slot but a different lap means the writer is a full lap ahead.
  assign o_full   = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) &&
                    (r_wr_ptr[IW] != r_rd_ptr[IW]);
  // Modular subtraction handles the rollover at 2*DEPTH for free.
  assign o_count  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch queue between I-cache return and decode. Buffers up to
// DEPTH {pc, inst} pairs with valid/ready handshakes on both sides and a
// single-cycle flush for redirects. in_ready depends only on occupancy.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, an empty
// queue forwards the input straight to the output combinationally and an
// entry taken that way is never written into storage.
// Ports:
//   CLK, RST_N          : clock, asynchronous active-low reset
//   flush               : discard all entries
//   in_valid/in_ready   : fetch-side handshake
//   in_pc/in_inst       : incoming entry
//   out_valid/out_ready : decode-side handshake
//   out_pc/out_inst     : head entry
//   count               : current occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH  = fetch_pkg::FETCH_Q_DEPTH,
  parameter int PC_W   = fetch_pkg::PC_W,
  parameter int INST_W = fetch_pkg::INST_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  import fetch_pkg::*;

  localparam int IW = $clog2(DEPTH);

  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];

  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass_take;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .flush    (flush),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .o_wr_idx (w_wr_idx),
    .o_rd_idx (w_rd_idx),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (count)
  );

  assign in_ready = ~w_full;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue whose consumer is ready hands the input straight through.
  assign w_bypass_take = w_empty & in_valid & out_ready & ~flush;

  // Output mux: bypass the input while empty, otherwise present the head
  always_comb begin
    if (w_empty) begin
      out_valid = in_valid & ~flush;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end else begin
      out_valid = 1'b1;
      out_pc    = r_pc_mem[w_rd_idx];
      out_inst  = r_inst_mem[w_rd_idx];
    end
  end
`else
  assign w_bypass_take = 1'b0;

  // Output mux: head entry straight from storage
  always_comb begin
    out_valid = ~w_empty;
    out_pc    = r_pc_mem[w_rd_idx];
    out_inst  = r_inst_mem[w_rd_idx];
  end
`endif

  // Storage writes are gated by flush so a discarded handshake leaves no trace.
  assign w_push = in_valid & ~w_full & ~flush & ~w_bypass_take;
  // Only entries actually held in storage advance the read pointer.
  assign w_pop  = out_ready & ~w_empty;

  // Storage array: cleared on reset, written at the write index on push
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[w_wr_idx]   <= in_pc;
      r_inst_mem[w_wr_idx] <= in_inst;
    end else begin
      r_pc_mem[w_wr_idx]   <= r_pc_mem[w_wr_idx];
      r_inst_mem[w_wr_idx] <= r_inst_mem[w_wr_idx];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed and randomized stimulus for fetch_queue, checked every cycle
// against a queue-based reference model of the buffering rules.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 4;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK;
  logic        RST_N;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t model_q[$];
  int   n_checks;
  int   n_errors;
  logic [31:0] next_pc;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .PC_W   (32),
    .INST_W (32)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, compare against the
  // model mid-low-phase, then apply the queue rules at the rising edge.
  task automatic cyc(input logic fl, input logic iv, input logic [31:0] pc,
                     input logic [31:0] inst, input logic ordy);
    int  sz;
    logic exp_v;
    @(negedge CLK);
    flush = fl; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #2;
    sz    = model_q.size();
    exp_v = (sz > 0) || (BYP && sz == 0 && iv && !fl);
    check("in_ready",  {31'd0, in_ready},  {31'd0, (sz < DEPTH)});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    check("count",     {29'd0, count},     32'(sz));
    if (sz > 0) begin
      check("out_pc",   out_pc,   model_q[0].pc);
      check("out_inst", out_inst, model_q[0].inst);
    end else if (exp_v) begin
      check("byp_pc",   out_pc,   pc);
      check("byp_inst", out_inst, inst);
    end
    @(posedge CLK);
    if (fl) begin
      model_q.delete();
    end else begin
      if (sz > 0 && ordy) void'(model_q.pop_front());
      if (iv && sz < DEPTH && !(BYP && sz == 0 && ordy))
        model_q.push_back('{pc: pc, inst: inst});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST_N = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_inst = 32'd0;

    // Reset state
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_count",     {29'd0, count},     32'd0);
    check("rst_out_pc",    out_pc,             32'd0);
    check("rst_out_inst",  out_inst,           32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Three pushes with decode stalled
    cyc(1'b0, 1'b1, 32'h100, 32'hA0000001, 1'b0);
    cyc(1'b0, 1'b1, 32'h104, 32'hA0000002, 1'b0);
    cyc(1'b0, 1'b1, 32'h108, 32'hA0000003, 1'b0);
    #1;
    check("three_count", {29'd0, count}, 32'd3);
    check("three_head",  out_pc,         32'h100);

    // Fill, attempt a fifth push, then pop one
    cyc(1'b0, 1'b1, 32'h10C, 32'hA0000004, 1'b0);
    cyc(1'b0, 1'b1, 32'h110, 32'hA0000005, 1'b0);
    #1;
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_count",    {29'd0, count},    32'd4);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    check("after_pop_ready", {31'd0, in_ready}, 32'd1);
    check("after_pop_count", {29'd0, count},    32'd3);

    // Sustained push+pop across the pointer wrap
    next_pc = 32'h200;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, next_pc, $urandom, 1'b1);
      next_pc = next_pc + 32'd4;
    end
    #1;
    check("stream_count", {29'd0, count}, 32'd3);

    // Flush with a simultaneous push; the flushed entry must never surface
    cyc(1'b1, 1'b1, 32'hDEAD0000, 32'hDEADBEEF, 1'b1);
    #1;
    check("flush_count", {29'd0, count},     32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready},  32'd1);
    cyc(1'b0, 1'b1, 32'h300, 32'hB0000001, 1'b0);
    cyc(1'b0, 1'b1, 32'h304, 32'hB0000002, 1'b0);
    #1;
    check("post_flush_head", out_pc, 32'h300);

    // Asynchronous reset mid-stream with two entries held
    @(negedge CLK);
    in_valid = 1'b0; in_pc = 32'd0; in_inst = 32'd0; out_ready = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_inst",  out_inst,           32'd0);
    check("mid_rst_count", {29'd0, count},     32'd0);
    check("mid_rst_ready", {31'd0, in_ready},  32'd1);
    model_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty-queue bypass: consumed in the same cycle, never stored
    cyc(1'b0, 1'b1, 32'h400, 32'h00000013, 1'b1);
    #1;
    check("byp_count", {29'd0, count}, 32'd0);
`endif

    // Randomized traffic with occasional flushes
    next_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
          next_pc, $urandom, ($urandom_range(0, 2) != 0));
      next_pc = next_pc + 32'd4;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the I-cache return path and the decode stage of the trv_proc pipeline. It buffers up to DEPTH fetched {pc, instruction} pairs, decoupling fetch from decode stalls with valid/ready handshakes on both sides. It supports a single-cycle flush for redirects. The block is synthesized and mapped onto the team's standard-cell library. Every flop is reset, so gate-level simulation stays X-free out of reset.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- PC_W, 32, program-counter width
- INST_W, 32, instruction width

- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (branch/exception redirect)
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue can accept an entry
- in_pc  in  PC_W  PC of the incoming instruction
- in_inst  in  INST_W  incoming instruction word
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts the head entry
- out_pc  out  PC_W  PC of the head entry
- out_inst  out  INST_W  head instruction word
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer of DEPTH entries.
- wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (index bits equal) and (wrap bits differ).
- count = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push = in_valid & in_ready. Writes mem[wr_ptr index] and increments wr_ptr.
- Pop = out_valid & out_ready. Increments rd_ptr.
- in_ready = !full. It does not depend on out_ready, so there is no combinational ready path through the queue.
- out_valid = !empty; out_pc/out_inst = mem[rd_ptr index].
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal whenever the queue is non-empty and not full.
- Pointers wrap naturally at 2·DEPTH. No special case is needed at the index rollover.
- Flush has priority over push and pop:
  - next cycle, wr_ptr = rd_ptr = 0 and count = 0;
  - any handshake in the flush cycle is discarded;
  - storage contents are left unchanged.
- Reset (RST_N low, any time including mid-transfer):
  - pointers and all storage entries go to 0 immediately;
  - out_valid=0, out_pc=0, out_inst=0, count=0, in_ready=1.

## Timing
- Without bypass: the latency from a push to out_valid is 1 cycle.
- Throughput is one push and one pop per cycle sustained.
- Full to not-full: in_ready rises in the cycle after a pop.
- Empty to not-empty: out_valid rises in the cycle after a push.
- After flush: out_valid=0 and in_ready=1 in the following cycle. A push is accepted in that cycle.
- Reset deassertion: the first push is accepted on the first rising edge with RST_N high.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - when the queue is empty, out_valid = in_valid and out_pc/out_inst = in_pc/in_inst combinationally;
  - if out_ready is also high, the entry is consumed in the same cycle and never written; pointers are unchanged;
  - flush still suppresses the bypass (out_valid=0 during flush).
- Undefined: no combinational path from input to output; minimum latency is 1 cycle.

## Structure
- Shared package fetch_pkg holds:
  - constants FETCH_Q_DEPTH=4, PC_W=32, INST_W=32;
  - typedef fetch_entry_t = struct {pc, inst}.
- One sub-module, fifo_ptr_ctrl: owns wr_ptr/rd_ptr, full/empty, count and flush handling.
- The top level holds the storage array and the optional bypass mux.

## Test plan
- Reset, then push pc=0x100/0x104/0x108 with out_ready=0 → count=3; out_pc=0x100 in the cycle after the first push.
- Fill to DEPTH=4 → in_ready=0 and a 5th in_valid is not accepted. Pop one → in_ready=1 the next cycle and count=3.
- Drive continuous push and pop for 20 cycles (crosses wrap) → out_pc sequence equals input order and count stays constant.
- Hold 3 entries, assert flush together with in_valid=1 → next cycle count=0, out_valid=0, and the flushed-cycle entry never appears.
- Assert RST_N low mid-stream with 2 entries → immediately out_valid=0, out_inst=0, count=0, in_ready=1.
- With FETCH_QUEUE_BYPASS_EN, empty queue, in_valid=1, out_ready=1, in_inst=0x00000013 → same cycle out_valid=1, out_inst=0x00000013, and count stays 0.
